// File: rtl/ir_nec_decoder.sv
// Pulse-distance (NEC-style) IR frame decoder: synchronises the receiver output, times
// marks and spaces in 10 us ticks, and reports codes, repeat presses and malformed frames.
module ir_nec_decoder #(
  parameter int CODEBITS      = 32,
  parameter int CLK_DIV       = 1000,
  parameter bit LSB_FIRST     = 1'b1,
  parameter bit CHECK_INV     = 1'b1,
  parameter bit RX_ACTIVE_LOW = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [CODEBITS-1:0] code_o,
  output logic                code_valid_o,
  output logic                repeat_press_o,
  output logic [7:0]          repeat_count_o,
  output logic                err_o,
  output logic                busy_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(CODEBITS + 1);

  localparam logic [11:0] LEAD_MIN     = 12'd800;
  localparam logic [11:0] SPACE_DATA   = 12'd350;
  localparam logic [11:0] SPACE_RPT    = 12'd175;
  localparam logic [11:0] MARK_MAX     = 12'd100;
  localparam logic [11:0] BIT_THRESH   = 12'd100;
  localparam logic [11:0] TIMEOUT      = 12'd250;
  localparam logic [11:0] TIMEOUT_LEAD = 12'd500;

  localparam logic IDLE_LVL = RX_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP,
    S_DONE,
    S_RPT_STOP,
    S_ERROR
  } state_e;

  logic                sync1_q, sync2_q, mark_q, mark_prev_q;
  logic                rise, fall, tick;
  logic [PW-1:0]       presc_q;
  logic [11:0]         len_q;
  state_e              state_q;
  logic [CODEBITS-1:0] shreg_q, shreg_d, code_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic                bit_val, inv_ok;
  logic                have_code_q, code_valid_q, repeat_press_q, err_q;
  logic [7:0]          rpt_cnt_q;

  // Sync resets to the idle line level so releasing reset never fakes a mark edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= IDLE_LVL;
      sync2_q     <= IDLE_LVL;
      mark_q      <= 1'b0;
      mark_prev_q <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      mark_q      <= sync2_q ^ IDLE_LVL;
      mark_prev_q <= mark_q;
    end
  end

  assign rise = mark_q & ~mark_prev_q;
  assign fall = ~mark_q & mark_prev_q;
  assign tick = (presc_q == PW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  // An edge wins over a coincident tick: the count restarts and that tick is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q <= '0;
    end else if (rise || fall) begin
      len_q <= '0;
    end else if (tick && (len_q != 12'hFFF)) begin
      len_q <= len_q + 12'd1;
    end
  end

  assign bit_val = (len_q >= BIT_THRESH);
  assign idx_d   = idx_q + IW'(1);

  always_comb begin
    shreg_d = shreg_q;
    if (LSB_FIRST) begin
      shreg_d = {bit_val, shreg_q[CODEBITS-1:1]};
    end else begin
      shreg_d = {shreg_q[CODEBITS-2:0], bit_val};
    end
  end

  generate
    if ((CODEBITS == 32) && CHECK_INV) begin : g_inv
      assign inv_ok = (shreg_q[31:24] == ~shreg_q[23:16]) &&
                      (shreg_q[15:8]  == ~shreg_q[7:0]);
    end else begin : g_noinv
      assign inv_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      idx_q          <= '0;
      code_q         <= '0;
      have_code_q    <= 1'b0;
      rpt_cnt_q      <= '0;
      code_valid_q   <= 1'b0;
      repeat_press_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      code_valid_q   <= 1'b0;
      repeat_press_q <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) state_q <= S_LEAD_MARK;
        end
        S_LEAD_MARK: begin
          if (fall) state_q <= (len_q >= LEAD_MIN) ? S_LEAD_SPACE : S_IDLE;
        end
        S_LEAD_SPACE: begin
          if (rise) begin
            if (len_q >= SPACE_DATA) begin
              state_q <= S_BIT_MARK;
              idx_q   <= '0;
              shreg_q <= '0;
            end else if (len_q >= SPACE_RPT) begin
              state_q <= S_RPT_STOP;
            end else begin
              state_q <= S_ERROR;
            end
          end else if (len_q >= TIMEOUT_LEAD) begin
            state_q <= S_ERROR;
          end
        end
        S_BIT_MARK: begin
          if (len_q > MARK_MAX) state_q <= S_ERROR;
          else if (fall)        state_q <= S_BIT_SPACE;
        end
        S_BIT_SPACE: begin
          if (rise) begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            state_q <= (idx_d == IW'(CODEBITS)) ? S_STOP : S_BIT_MARK;
          end else if (len_q >= TIMEOUT) begin
            state_q <= S_ERROR;
          end
        end
        S_STOP: begin
          if (len_q > MARK_MAX) state_q <= S_ERROR;
          else if (fall)        state_q <= S_DONE;
        end
        S_DONE: begin
          if (inv_ok) begin
            code_q       <= shreg_q;
            code_valid_q <= 1'b1;
            rpt_cnt_q    <= '0;
            have_code_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        S_RPT_STOP: begin
          if (len_q > MARK_MAX) begin
            state_q <= S_ERROR;
          end else if (fall) begin
            if (have_code_q) begin
              repeat_press_q <= 1'b1;
              if (rpt_cnt_q != 8'hFF) rpt_cnt_q <= rpt_cnt_q + 8'd1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        S_ERROR: begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign code_o         = code_q;
  assign code_valid_o   = code_valid_q;
  assign repeat_press_o = repeat_press_q;
  assign repeat_count_o = rpt_cnt_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
